// File: rtl/ffdebounce_pkg.sv
// ffdebounce_pkg
// Purpose : shared constant helpers for the ffdebounce block.
// Contents: clog2 - ceiling log2 used to size the per-bit stability counters.
package ffdebounce_pkg;

    // Ceiling log2 of a positive value; clog2(1) = 0, clog2(2) = 1, clog2(16) = 4.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'd1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/ffdebounce_bit.sv
// ffdebounce_bit
// Purpose : debounce and edge-detect a single already-synchronized bit.
//           The output follows the input only after the input has differed
//           from the output for STABLE_CYCLES consecutive enabled edges.
// Ports   :
//   clk_i   in   clock, rising edge
//   rst_ni  in   synchronous active-low reset
//   ena_i   in   sample enable; the counter advances only when high
//   data_i  in   synchronized input bit
//   data_o  out  debounced bit (registered)
//   rise_o  out  one-cycle pulse on an accepted 0->1 change (registered)
//   fall_o  out  one-cycle pulse on an accepted 1->0 change (registered)
module ffdebounce_bit
    import ffdebounce_pkg::*;
#(
    parameter int   STABLE_CYCLES = 16,
    parameter logic RESET_VAL     = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic ena_i,
    input  logic data_i,
    output logic data_o,
    output logic rise_o,
    output logic fall_o
);

    // At least one counter bit even when STABLE_CYCLES is 1.
    localparam int CNT_W = clog2((STABLE_CYCLES > 2) ? STABLE_CYCLES : 2);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    generate
        if (STABLE_CYCLES < 1) begin : g_bad_stable_cycles
            $error("ffdebounce_bit: STABLE_CYCLES must be 1 or more");
        end
    endgenerate

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt    <= '0;
            data_o <= RESET_VAL;
            rise_o <= 1'b0;
            fall_o <= 1'b0;
        end else begin
            rise_o <= 1'b0;
            fall_o <= 1'b0;
            if (data_i == data_o) begin
                // Input agrees with output: any partial count is a glitch, drop it.
                cnt <= '0;
            end else if (ena_i) begin
                if (cnt == CNT_MAX) begin
                    // This enabled edge completes the stable run: commit.
                    data_o <= data_i;
                    cnt    <= '0;
                    rise_o <= data_i;
                    fall_o <= ~data_i;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
            // Differing input with ena_i low: count and output hold.
        end
    end

endmodule

// File: rtl/ffdebounce.sv
// ffdebounce
// Purpose : per-bit debouncer and edge detector for a bus already
//           synchronized into clk_i. Every bit is independent.
// Ports   :
//   clk_i   in   [1]      clock, rising edge
//   rst_ni  in   [1]      synchronous active-low reset
//   ena_i   in   [1]      sample enable shared by all bits
//   data_i  in   [WIDTH]  synchronized input bus
//   data_o  out  [WIDTH]  debounced bus (registered)
//   rise_o  out  [WIDTH]  per-bit accepted 0->1 pulse (registered)
//   fall_o  out  [WIDTH]  per-bit accepted 1->0 pulse (registered)
module ffdebounce
    import ffdebounce_pkg::*;
#(
    parameter int               WIDTH         = 8,
    parameter int               STABLE_CYCLES = 16,
    parameter logic [WIDTH-1:0] RESET_VAL     = {WIDTH{1'b0}}
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             ena_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o
);

    generate
        if (STABLE_CYCLES < 1) begin : g_bad_stable_cycles
            $error("ffdebounce: STABLE_CYCLES must be 1 or more");
        end
    endgenerate

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        ffdebounce_bit #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .RESET_VAL     (RESET_VAL[i])
        ) u_bit (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .ena_i  (ena_i),
            .data_i (data_i[i]),
            .data_o (data_o[i]),
            .rise_o (rise_o[i]),
            .fall_o (fall_o[i])
        );
    end

endmodule

// File: tb/tb_ffdebounce.sv
// tb_ffdebounce
// Purpose : directed self-checking bench for ffdebounce with WIDTH=4,
//           STABLE_CYCLES=4, RESET_VAL=4'b0000.
module tb_ffdebounce;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         ena;
    logic [W-1:0] din;
    logic [W-1:0] dout;
    logic [W-1:0] rise;
    logic [W-1:0] fall;

    int checks;
    int errors;

    ffdebounce #(
        .WIDTH         (W),
        .STABLE_CYCLES (4),
        .RESET_VAL     (4'b0000)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .ena_i  (ena),
        .data_i (din),
        .data_o (dout),
        .rise_o (rise),
        .fall_o (fall)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        rst_n = 1'b0;
        ena   = 1'b1;
        din   = '0;
    end

    // Driver: advance one rising edge, then settle 1 time unit so that the
    // outputs of that edge are sampled well away from the next one.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [W-1:0] ed, er;
        rst_n = 1'b0;
        ena   = 1'b1;
        din   = 4'hF;
        tick();
        tick();
        checks++;
        if (dout !== 4'h0 || rise !== 4'h0 || fall !== 4'h0) begin
            errors++;
            $display("FAIL reset_hold: data_o=%h rise_o=%h fall_o=%h expected 0 0 0", dout, rise, fall);
        end
        rst_n = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            ed = (i >= 4) ? 4'hF : 4'h0;
            er = (i == 4) ? 4'hF : 4'h0;
            checks++;
            if (dout !== ed || rise !== er || fall !== 4'h0) begin
                errors++;
                $display("FAIL reset_release edge %0d: data_o=%h rise_o=%h fall_o=%h expected %h %h 0",
                         i, dout, rise, fall, ed, er);
            end
        end
        // Return all bits to 0: simultaneous fall on every bit.
        din = 4'h0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            ed = (i == 4) ? 4'h0 : 4'hF;
            checks++;
            if (dout !== ed || rise !== 4'h0 || fall !== ((i == 4) ? 4'hF : 4'h0)) begin
                errors++;
                $display("FAIL all_fall edge %0d: data_o=%h rise_o=%h fall_o=%h expected %h 0 %h",
                         i, dout, rise, fall, ed, (i == 4) ? 4'hF : 4'h0);
            end
        end
    endtask

    task automatic test_single_rise();
        logic [W-1:0] ed, er;
        din = 4'b0001;
        for (int i = 1; i <= 5; i++) begin
            tick();
            ed = (i >= 4) ? 4'b0001 : 4'b0000;
            er = (i == 4) ? 4'b0001 : 4'b0000;
            checks++;
            if (dout !== ed || rise !== er || fall !== 4'h0) begin
                errors++;
                $display("FAIL single_rise edge %0d: data_o=%h rise_o=%h fall_o=%h expected %h %h 0",
                         i, dout, rise, fall, ed, er);
            end
        end
    endtask

    task automatic test_glitch();
        logic [W-1:0] ed, er;
        // Bit 1 high for 3 edges, back low for 1, then high again.
        din = 4'b0011;
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++;
            if (dout !== 4'b0001 || rise !== 4'h0 || fall !== 4'h0) begin
                errors++;
                $display("FAIL glitch_pre edge %0d: data_o=%h rise_o=%h fall_o=%h expected 1 0 0",
                         i, dout, rise, fall);
            end
        end
        din = 4'b0001;
        tick();
        checks++;
        if (dout !== 4'b0001 || rise !== 4'h0 || fall !== 4'h0) begin
            errors++;
            $display("FAIL glitch_drop: data_o=%h rise_o=%h fall_o=%h expected 1 0 0", dout, rise, fall);
        end
        din = 4'b0011;
        for (int i = 1; i <= 4; i++) begin
            tick();
            ed = (i == 4) ? 4'b0011 : 4'b0001;
            er = (i == 4) ? 4'b0010 : 4'b0000;
            checks++;
            if (dout !== ed || rise !== er || fall !== 4'h0) begin
                errors++;
                $display("FAIL glitch_post edge %0d: data_o=%h rise_o=%h fall_o=%h expected %h %h 0",
                         i, dout, rise, fall, ed, er);
            end
        end
    endtask

    task automatic test_enable();
        logic [W-1:0] ed, er;
        // Clear back to zero first (bits 0 and 1 fall together).
        din = 4'b0000;
        for (int i = 1; i <= 4; i++) begin
            tick();
            checks++;
            if (dout !== ((i == 4) ? 4'b0000 : 4'b0011) || fall !== ((i == 4) ? 4'b0011 : 4'b0000)) begin
                errors++;
                $display("FAIL enable_clear edge %0d: data_o=%h fall_o=%h", i, dout, fall);
            end
        end
        // Enable alternates 1,0,1,... : 4th enabled edge is overall edge 7.
        din = 4'b0100;
        for (int i = 1; i <= 8; i++) begin
            ena = (i % 2 == 1);
            tick();
            ed = (i >= 7) ? 4'b0100 : 4'b0000;
            er = (i == 7) ? 4'b0100 : 4'b0000;
            checks++;
            if (dout !== ed || rise !== er || fall !== 4'h0) begin
                errors++;
                $display("FAIL enable_gate edge %0d: data_o=%h rise_o=%h fall_o=%h expected %h %h 0",
                         i, dout, rise, fall, ed, er);
            end
        end
        ena = 1'b1;
    endtask

    task automatic test_fall();
        logic [W-1:0] ed, ef;
        din = 4'b0101;
        for (int i = 1; i <= 4; i++) begin
            tick();
            checks++;
            if (dout !== ((i == 4) ? 4'b0101 : 4'b0100) || rise !== ((i == 4) ? 4'b0001 : 4'b0000)) begin
                errors++;
                $display("FAIL fall_setup edge %0d: data_o=%h rise_o=%h", i, dout, rise);
            end
        end
        din = 4'b0000;
        for (int i = 1; i <= 5; i++) begin
            tick();
            ed = (i >= 4) ? 4'b0000 : 4'b0101;
            ef = (i == 4) ? 4'b0101 : 4'b0000;
            checks++;
            if (dout !== ed || rise !== 4'h0 || fall !== ef) begin
                errors++;
                $display("FAIL fall edge %0d: data_o=%h rise_o=%h fall_o=%h expected %h 0 %h",
                         i, dout, rise, fall, ed, ef);
            end
        end
    endtask

    task automatic test_reset_mid_count();
        logic [W-1:0] ed, er;
        din = 4'b1000;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        checks++;
        if (dout !== 4'h0 || rise !== 4'h0 || fall !== 4'h0) begin
            errors++;
            $display("FAIL reset_mid: data_o=%h rise_o=%h fall_o=%h expected 0 0 0", dout, rise, fall);
        end
        rst_n = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            ed = (i >= 4) ? 4'b1000 : 4'b0000;
            er = (i == 4) ? 4'b1000 : 4'b0000;
            checks++;
            if (dout !== ed || rise !== er || fall !== 4'h0) begin
                errors++;
                $display("FAIL reset_mid_release edge %0d: data_o=%h rise_o=%h fall_o=%h expected %h %h 0",
                         i, dout, rise, fall, ed, er);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single_rise();
        test_glitch();
        test_enable();
        test_fall();
        test_reset_mid_count();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ffdebounce.md
Name: ffdebounce

Overview:
- Per-bit debouncer and edge detector on a bus that has already been brought into the clk_i domain by the synchronizer chain.
- Each bit changes its output only after the new input value has held for STABLE_CYCLES consecutive enabled clock edges.
- Alongside each accepted change it emits a one-cycle rise or fall pulse.
- Typical users: push-buttons, jumpers and slow status lines feeding control logic.

Parameters:
- WIDTH, 8, number of independent bits.
- STABLE_CYCLES, 16, consecutive enabled differing samples needed to accept a change. Legal range is 1 or more; values below 1 are illegal and the elaboration check fails.
- RESET_VAL, {WIDTH{1'b0}}, value loaded into data_o by reset.

Ports:
- clk_i  input  1  single clock; all logic on its rising edge.
- rst_ni  input  1  synchronous, active-low reset.
- ena_i  input  1  sample enable; counters advance only when ena_i=1.
- data_i  input  WIDTH  bus, already synchronized to clk_i.
- data_o  output  WIDTH  debounced value, registered.
- rise_o  output  WIDTH  one-cycle pulse per bit on an accepted 0->1 change, registered.
- fall_o  output  WIDTH  one-cycle pulse per bit on an accepted 1->0 change, registered.

Behaviour:
- One clock domain, clk_i. Reset is synchronous and active-low on rst_ni, sampled at the clk_i rising edge.
- Reset:
  - data_o <= RESET_VAL; rise_o <= 0; fall_o <= 0; all counters <= 0.
  - Reset has priority over ena_i and data_i.
  - Reset in the middle of a count discards the partial count.
- Counter: one per bit, CNT_W = clog2(max(STABLE_CYCLES,2)) bits wide, range 0..STABLE_CYCLES-1.
- Per bit b, at each edge when not in reset, evaluated in this priority order:
  - data_i[b] == data_o[b]: cnt <= 0, regardless of ena_i. Any glitch back to the current value restarts the count.
  - data_i[b] != data_o[b] and ena_i=0: cnt holds, data_o[b] holds.
  - data_i[b] != data_o[b], ena_i=1 and cnt < STABLE_CYCLES-1: cnt <= cnt+1.
  - data_i[b] != data_o[b], ena_i=1 and cnt == STABLE_CYCLES-1: data_o[b] <= data_i[b]; cnt <= 0; rise_o[b] <= data_i[b]; fall_o[b] <= ~data_i[b].
- Pulses:
  - rise_o and fall_o default to 0 every edge.
  - Each pulse lasts exactly one clock and is coincident with the data_o transition.
  - rise_o[b] and fall_o[b] are never high together.
- Latency with ena_i held at 1:
  - Input changes before edge k; data_o updates at edge k+STABLE_CYCLES-1.
  - STABLE_CYCLES=1 makes the block a plain enabled register with edge pulses.
- Bits are fully independent; simultaneous changes on several bits produce simultaneous pulses.
- No counter overflow or wrap: the count saturates at STABLE_CYCLES-1, where it either commits or clears.
- No combinational path from any input to any output.

Decomposition:
- Shared package: constant function clog2. Nothing else is shared; the block has no typedefs.
- One sub-module, ffdebounce_bit: a single bit holding its counter, output register and pulse registers. The top level instantiates it WIDTH times in a generate loop and passes STABLE_CYCLES and the bit's RESET_VAL.

Test Plan (WIDTH=4, STABLE_CYCLES=4, RESET_VAL=4'b0000):
- rst_ni=0 for 2 edges with data_i=4'hF, ena_i=1 -> data_o=4'h0, rise_o=fall_o=0. Release reset with data_i=4'hF held -> data_o=4'hF at the 4th edge after release, rise_o=4'hF for 1 cycle.
- From data_o=0, set data_i=4'b0001 with ena_i=1 -> data_o=4'b0001 after the 4th edge; rise_o=4'b0001 on that cycle only.
- Glitch: data_i[1]=1 for 3 edges, then 0 for 1 edge, then 1 again -> no change for the first 3 edges and no pulses. data_o[1]=1 only after 4 further consecutive edges.
- Enable gating: data_i=4'b0100 held, ena_i alternating 1,0,1,0,... starting at 1 -> data_o[2] updates at the 7th edge, i.e. the 4th enabled edge. The count holds through the ena_i=0 edges.
- Fall: with data_o=4'b0101, data_i=4'b0000 -> data_o=0 after 4 edges; fall_o=4'b0101 for one cycle; rise_o stays 0.
- Reset mid-count: data_i=4'b1000 for 2 edges, rst_ni=0 for 1 edge, then release -> data_o stays 0 until 4 full edges after release.
